// File: rtl/vending_machine.sv
// Coin-accumulating vending controller: adds each coin to a credit register and
// emits a one-cycle dispense pulse with change once the credit covers the price.
module vending_machine (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] in,
    input  logic [2:0] p,
    output logic       out,
    output logic [2:0] change
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] credit;
    logic [3:0] credit_next;
    logic       out_next;
    logic [2:0] change_next;
    logic [3:0] sum;
    logic [3:0] price;

    assign sum   = credit + {1'b0, in};
    assign price = {1'b0, p};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            credit <= 4'd0;
            out    <= 1'b0;
            change <= 3'd0;
        end else begin
            state  <= state_next;
            credit <= credit_next;
            out    <= out_next;
            change <= change_next;
        end
    end

    // A zero price means out of service: coins are ignored and credit is held.
    always_comb begin
        state_next  = IDLE;
        credit_next = credit;
        out_next    = 1'b0;
        change_next = 3'd0;

        if (p == 3'd0) begin
            credit_next = credit;
            state_next  = (credit == 4'd0) ? IDLE : COLLECT;
        end else if (sum >= price) begin
            state_next  = VEND;
            credit_next = 4'd0;
            out_next    = 1'b1;
            change_next = 3'(sum - price);
        end else if (sum != 4'd0) begin
            state_next  = COLLECT;
            credit_next = sum;
        end else begin
            state_next  = IDLE;
            credit_next = 4'd0;
        end
    end

endmodule

// File: tb/tb_vending_machine.sv
// Scoreboard bench for vending_machine: each scenario pushes the expected
// out/change for every edge it drives and compares once the edge has passed.
module tb_vending_machine;

    typedef struct {
        logic       o;
        logic [2:0] c;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [2:0] coin;
    logic [2:0] price;
    logic       out;
    logic [2:0] change;

    exp_t sb[$];
    exp_t e;
    int   checks;
    int   errors;

    vending_machine dut (
        .clk    (clk),
        .rst    (rst),
        .in     (coin),
        .p      (price),
        .out    (out),
        .change (change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one edge's inputs, record what the dispenser must show after it.
    task automatic drive(input logic [2:0] c, input logic [2:0] pr,
                         input logic eo, input logic [2:0] ec);
        exp_t x;
        coin  = c;
        price = pr;
        x.o = eo;
        x.c = ec;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        coin  = 3'd0;
        price = 3'd0;
        #2;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        exp_t x;
        rst   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(3'd7, 3'd1, 1'b0, 3'd0);
            e = sb.pop_front();
            checks++;
            if (out !== e.o || change !== e.c) begin
                errors++;
                $display("FAIL reset_hold[%0d]: out=%b change=%0d, expected out=%b change=%0d",
                         i, out, change, e.o, e.c);
            end
        end
        rst = 1'b1;
        drive(3'd3, 3'd2, 1'b1, 3'd1);
        e = sb.pop_front();
        checks++;
        if (out !== e.o || change !== e.c) begin
            errors++;
            $display("FAIL reset_release_vend: out=%b change=%0d, expected out=%b change=%0d",
                     out, change, e.o, e.c);
        end
        #2;
        rst = 1'b0;
        #1;
        x.o = 1'b0;
        x.c = 3'd0;
        sb.push_back(x);
        e = sb.pop_front();
        checks++;
        if (out !== e.o || change !== e.c) begin
            errors++;
            $display("FAIL reset_async: out=%b change=%0d, expected out=%b change=%0d",
                     out, change, e.o, e.c);
        end
        rst = 1'b1;
        drive(3'd2, 3'd5, 1'b0, 3'd0);
        e = sb.pop_front();
        checks++;
        if (out !== e.o || change !== e.c) begin
            errors++;
            $display("FAIL reset_collect: out=%b change=%0d, expected out=%b change=%0d",
                     out, change, e.o, e.c);
        end
        #2;
        rst = 1'b0;
        #1;
        rst = 1'b1;
        // Credit of 2 must be gone: 3 alone stays below 5.
        drive(3'd3, 3'd5, 1'b0, 3'd0);
        e = sb.pop_front();
        checks++;
        if (out !== e.o || change !== e.c) begin
            errors++;
            $display("FAIL reset_credit_cleared: out=%b change=%0d, expected out=%b change=%0d",
                     out, change, e.o, e.c);
        end
    endtask

    task automatic test_exact();
        logic [2:0] ci [4] = '{3'd1, 3'd1, 3'd1, 3'd0};
        logic       eo [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(ci[i], 3'd3, eo[i], 3'd0);
            e = sb.pop_front();
            checks++;
            if (out !== e.o || change !== e.c) begin
                errors++;
                $display("FAIL exact[%0d]: out=%b change=%0d, expected out=%b change=%0d",
                         i, out, change, e.o, e.c);
            end
        end
    endtask

    task automatic test_mixed();
        logic [2:0] ci [3] = '{3'd1, 3'd1, 3'd2};
        logic       eo [3] = '{1'b0, 1'b0, 1'b1};
        logic [2:0] ec [3] = '{3'd0, 3'd0, 3'd1};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(ci[i], 3'd3, eo[i], ec[i]);
            e = sb.pop_front();
            checks++;
            if (out !== e.o || change !== e.c) begin
                errors++;
                $display("FAIL mixed[%0d]: out=%b change=%0d, expected out=%b change=%0d",
                         i, out, change, e.o, e.c);
            end
        end
    endtask

    task automatic test_stream();
        logic [2:0] pr [7] = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd2, 3'd2, 3'd2};
        logic       eo [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [2:0] ec [7] = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(3'd2, pr[i], eo[i], ec[i]);
            e = sb.pop_front();
            checks++;
            if (out !== e.o || change !== e.c) begin
                errors++;
                $display("FAIL stream[%0d]: out=%b change=%0d, expected out=%b change=%0d",
                         i, out, change, e.o, e.c);
            end
        end
    endtask

    task automatic test_max_change();
        logic [2:0] ci [2] = '{3'd6, 3'd7};
        logic       eo [2] = '{1'b0, 1'b1};
        logic [2:0] ec [2] = '{3'd0, 3'd6};
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(ci[i], 3'd7, eo[i], ec[i]);
            e = sb.pop_front();
            checks++;
            if (out !== e.o || change !== e.c) begin
                errors++;
                $display("FAIL max_change[%0d]: out=%b change=%0d, expected out=%b change=%0d",
                         i, out, change, e.o, e.c);
            end
        end
    endtask

    // Out of service drops coins; later steps show credit both stayed 0 and is held.
    task automatic test_out_of_service();
        logic [2:0] ci [9] = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd0, 3'd2, 3'd3, 3'd3, 3'd0};
        logic [2:0] pr [9] = '{3'd0, 3'd0, 3'd5, 3'd5, 3'd3, 3'd5, 3'd0, 3'd0, 3'd2};
        logic       eo [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [2:0] ec [9] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(ci[i], pr[i], eo[i], ec[i]);
            e = sb.pop_front();
            checks++;
            if (out !== e.o || change !== e.c) begin
                errors++;
                $display("FAIL out_of_service[%0d]: out=%b change=%0d, expected out=%b change=%0d",
                         i, out, change, e.o, e.c);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] ci [4] = '{3'd4, 3'd5, 3'd1, 3'd0};
        logic       eo [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [2:0] ec [4] = '{3'd1, 3'd2, 3'd0, 3'd0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(ci[i], 3'd3, eo[i], ec[i]);
            e = sb.pop_front();
            checks++;
            if (out !== e.o || change !== e.c) begin
                errors++;
                $display("FAIL back_to_back[%0d]: out=%b change=%0d, expected out=%b change=%0d",
                         i, out, change, e.o, e.c);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        coin   = 3'd0;
        price  = 3'd0;
        #1;
        test_reset();
        test_exact();
        test_mixed();
        test_stream();
        test_max_change();
        test_out_of_service();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vending_machine.md
Name: vending_machine

Overview:
- Coin-accumulating vending controller.
- Each clock it adds the value on `in` to an internal credit and compares the credit against the price presented on `p`.
- When the credit reaches or exceeds the price, it pulses `out` for one cycle with the excess on `change`, then clears the credit.
- Stand-alone leaf block; the coin acceptor and price selector drive it directly.

Parameters:
- None. All data paths are fixed at 3 bits; the internal credit register is 4 bits.

Ports:
- `clk`  input  1  Rising-edge clock.
- `rst`  input  1  Asynchronous, active-low reset (0 = reset).
- `in`  input  3  Coin value inserted this cycle, unsigned units. 0 means no coin.
- `p`  input  3  Price of the selected product, unsigned units. 0 means out of service.
- `out`  output  1  Dispense pulse, registered, high for one cycle per vend.
- `change`  output  3  Change to return, registered. Valid only while `out`=1, otherwise 0.

Behaviour:
- Reset (`rst`=0, asynchronous): `state`=IDLE, `credit`=0, `out`=0, `change`=0, all taking effect immediately. Normal operation resumes on the first rising edge after `rst` returns to 1.
- Coin sampling is level-based per edge: every rising edge with `in`≠0 counts as one insertion of value `in`. Holding `in` for N edges inserts N coins; there is no edge detection.
- Next credit: `sum` = `credit` + `in`, computed 4 bits wide. The maximum is 6+7=13, so there is no overflow.
- `p` is sampled combinationally each edge; a price change mid-transaction applies at the next edge.
- States:
  - IDLE: `credit`=0, `out`=0.
  - COLLECT: 0<`credit`<`p`, `out`=0.
  - VEND: one-cycle dispense, `out`=1, `change` valid, `credit` already 0.
- Transitions, evaluated each rising edge when `p`≠0, from any state:
  - `sum`>=`p`: go to VEND; `out`<=1, `change`<=`sum`−`p` (0..6), `credit`<=0.
  - 0<`sum`<`p`: go to COLLECT; `credit`<=`sum`, `out`<=0, `change`<=0.
  - `sum`=0: go to IDLE; `out`<=0, `change`<=0.
- In VEND, `credit` is 0, so `sum`=`in`. A coin arriving in the VEND cycle starts a new transaction.
  - If that coin alone meets the price, VEND repeats and `out` stays 1 for a second consecutive cycle with a fresh `change`.
- Price lowered below the held credit: the next edge vends even with `in`=0, because `sum`=`credit`>=`p`.
- `p`=0 (out of service): coins are ignored and `credit` holds its value. Go to IDLE if `credit`=0, else COLLECT; `out`=0, `change`=0. Credit is preserved until a nonzero price returns.
- `out` and `change` are registered; no combinational path from the inputs.
- Latency: the vend pulse appears after the same edge that sampled the completing coin.
- Change width: 3 bits is sufficient because pre-coin credit ≤ `p`−1 and `in` ≤ 7, so `change` ≤ 6.

Test Plan:
- Reset: hold `rst`=0 with `in`=7, `p`=1 for 3 edges → `out`=0, `change`=0 throughout. Assert `rst`=0 mid-COLLECT → `out`/`change`/`credit` go to 0 before the next edge.
- Exact payment: `p`=3; `in`=1 for 3 edges then 0 → `out`=0, 0, then 1 for one cycle with `change`=0, then 0.
- Mixed coins with change: `p`=3; `in`=1 for 2 edges, then `in`=2 for one edge → vend on the third edge, `change`=1.
- Continuous coin stream: `p`=3, `in`=2 held → per edge `out`=0,1,0,1…, `change`=1 on each vend cycle. Then `p`=2, `in`=2 held → `out`=1 every edge, `change`=0.
- Maximum change: `p`=7; `in`=6 for one edge, then `in`=7 → `out`=1, `change`=6.
- Out of service and price change: `p`=0, `in`=2 for 2 edges → no vend, `credit` stays 0. Then `p`=5, `in`=2 for 2 edges (`credit`=4), `in`=0, `p`=3 → vend on the next edge, `change`=1.
